// File: rtl/mem_stage_if.sv
// ============================================================================
// Module      : mem_stage_if
// Description : Data-memory request/response bundle between the MEM pipeline
//               stage (master) and the data memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_stage_if;
  logic        Dm_Req;
  logic        Dm_We;
  logic [31:0] Dm_Addr;
  logic [31:0] Dm_Wdata;
  logic [31:0] Dm_Rdata;
  logic        Dm_Ack;

  // Pipeline side issues requests and consumes the response.
  modport master (
    output Dm_Req, Dm_We, Dm_Addr, Dm_Wdata,
    input  Dm_Rdata, Dm_Ack
  );

  // Memory side accepts requests and returns data with a one-cycle Ack.
  modport slave (
    input  Dm_Req, Dm_We, Dm_Addr, Dm_Wdata,
    output Dm_Rdata, Dm_Ack
  );
endinterface

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// Module      : mem_stage
// Description : MEM pipeline stage. Issues word-aligned loads/stores to a
//               variable-latency data memory, stalls the front of the pipe
//               while the access is outstanding, aborts on misalignment or
//               after TIMEOUT wait cycles, and registers results into MEM/WB.
//               All state updates on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage #(
  parameter int TIMEOUT = 15
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic [31:0] MEM_ALUout,
  input  logic [31:0] MEM_busB,
  input  logic [4:0]  MEM_Rw,
  input  logic        MEM_Zero,
  input  logic        MEM_Overflow,
  input  logic        MEM_RegWr,
  input  logic        MEM_MemtoReg,
  input  logic        MEM_MemWr,
  input  logic        MEM_Branch,
  input  logic        MEM_Jump,
  mem_stage_if.master dm,
  output logic        MEM_PCSrc,
  output logic        Stall,
  output logic        WB_RegWr,
  output logic        WB_MemtoReg,
  output logic [4:0]  WB_Rw,
  output logic [31:0] WB_ALUout,
  output logic [31:0] WB_Dout,
  output logic        MemErr
);

  // Counter must reach TIMEOUT-1; never narrower than 4 bits.
  localparam int CNT_BITS = $clog2(TIMEOUT + 1);
  localparam int CNT_W    = (CNT_BITS > 4) ? CNT_BITS : 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             mem_op;
  logic             aligned;
  logic             timed_out;

  assign mem_op    = MEM_MemtoReg | MEM_MemWr;
  assign aligned   = (MEM_ALUout[1:0] == 2'b00);
  assign timed_out = (cnt == CNT_LAST);

  // Control transfer resolves here regardless of any memory access in flight.
  assign MEM_PCSrc = (MEM_Branch & MEM_Zero) | MEM_Jump;

  // Stall holds the upstream stages until the access completes or aborts;
  // it drops in the final cycle so the pipe advances on the same edge.
  always_comb begin
    Stall = 1'b0;
    case (state)
      S_IDLE:  Stall = mem_op & aligned;
      S_WAIT:  Stall = ~(dm.Dm_Ack | timed_out);
      default: Stall = 1'b0;
    endcase
  end

  // Access FSM, memory request registers and MEM/WB pipeline register.
  always_ff @(negedge Clk) begin
    if (Clr) begin
      state       <= S_IDLE;
      cnt         <= '0;
      dm.Dm_Req   <= 1'b0;
      dm.Dm_We    <= 1'b0;
      dm.Dm_Addr  <= '0;
      dm.Dm_Wdata <= '0;
      WB_RegWr    <= 1'b0;
      WB_MemtoReg <= 1'b0;
      WB_Rw       <= '0;
      WB_ALUout   <= '0;
      WB_Dout     <= '0;
      MemErr      <= 1'b0;
    end else begin
      MemErr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!mem_op) begin
            // Plain ALU op: pass through, suppressing writeback on overflow.
            WB_RegWr    <= MEM_RegWr & ~MEM_Overflow;
            WB_MemtoReg <= MEM_MemtoReg;
            WB_Rw       <= MEM_Rw;
            WB_ALUout   <= MEM_ALUout;
          end else if (aligned) begin
            dm.Dm_Req   <= 1'b1;
            dm.Dm_We    <= MEM_MemWr;
            dm.Dm_Addr  <= MEM_ALUout;
            dm.Dm_Wdata <= MEM_busB;
            cnt         <= '0;
            state       <= S_WAIT;
            WB_RegWr    <= 1'b0;
            WB_MemtoReg <= 1'b0;
          end else begin
            // Misaligned: drop the instruction and flag it.
            MemErr      <= 1'b1;
            WB_RegWr    <= 1'b0;
            WB_MemtoReg <= 1'b0;
          end
        end
        S_WAIT: begin
          if (dm.Dm_Ack) begin
            // Ack takes priority over a coincident timeout.
            dm.Dm_Req   <= 1'b0;
            cnt         <= '0;
            state       <= S_IDLE;
            WB_Dout     <= dm.Dm_Rdata;
            WB_RegWr    <= MEM_RegWr;
            WB_MemtoReg <= MEM_MemtoReg;
            WB_Rw       <= MEM_Rw;
            WB_ALUout   <= MEM_ALUout;
          end else if (timed_out) begin
            dm.Dm_Req   <= 1'b0;
            cnt         <= '0;
            state       <= S_IDLE;
            MemErr      <= 1'b1;
            WB_RegWr    <= 1'b0;
            WB_MemtoReg <= 1'b0;
          end else begin
            cnt         <= cnt + CNT_W'(1);
            WB_RegWr    <= 1'b0;
            WB_MemtoReg <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module      : tb_mem_stage
// Description : Directed self-checking bench for mem_stage. DUT state moves
//               on the falling edge; stimulus is applied and outputs sampled
//               just after the rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;

  logic        Clk;
  logic        Clr;
  logic [31:0] MEM_ALUout, MEM_busB;
  logic [4:0]  MEM_Rw;
  logic        MEM_Zero, MEM_Overflow, MEM_RegWr, MEM_MemtoReg, MEM_MemWr;
  logic        MEM_Branch, MEM_Jump;
  logic        MEM_PCSrc, Stall, WB_RegWr, WB_MemtoReg, MemErr;
  logic [4:0]  WB_Rw;
  logic [31:0] WB_ALUout, WB_Dout;

  int total = 0;
  int bad   = 0;

  mem_stage_if dm_bus ();

  mem_stage #(.TIMEOUT(15)) dut (
    .Clk          (Clk),
    .Clr          (Clr),
    .MEM_ALUout   (MEM_ALUout),
    .MEM_busB     (MEM_busB),
    .MEM_Rw       (MEM_Rw),
    .MEM_Zero     (MEM_Zero),
    .MEM_Overflow (MEM_Overflow),
    .MEM_RegWr    (MEM_RegWr),
    .MEM_MemtoReg (MEM_MemtoReg),
    .MEM_MemWr    (MEM_MemWr),
    .MEM_Branch   (MEM_Branch),
    .MEM_Jump     (MEM_Jump),
    .dm           (dm_bus.master),
    .MEM_PCSrc    (MEM_PCSrc),
    .Stall        (Stall),
    .WB_RegWr     (WB_RegWr),
    .WB_MemtoReg  (WB_MemtoReg),
    .WB_Rw        (WB_Rw),
    .WB_ALUout    (WB_ALUout),
    .WB_Dout      (WB_Dout),
    .MemErr       (MemErr)
  );

  initial Clk = 1'b1;
  always #5 Clk = ~Clk;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance past one falling (update) edge to just after the next rising edge.
  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic nop();
    MEM_ALUout = '0; MEM_busB = '0; MEM_Rw = '0;
    MEM_Zero = 0; MEM_Overflow = 0; MEM_RegWr = 0;
    MEM_MemtoReg = 0; MEM_MemWr = 0; MEM_Branch = 0; MEM_Jump = 0;
    dm_bus.Dm_Ack = 0; dm_bus.Dm_Rdata = '0;
  endtask

  task automatic set_op(input logic [31:0] alu, input logic [31:0] busb, input logic [4:0] rw,
                        input logic regwr, input logic m2r, input logic memwr);
    MEM_ALUout = alu; MEM_busB = busb; MEM_Rw = rw;
    MEM_RegWr = regwr; MEM_MemtoReg = m2r; MEM_MemWr = memwr;
  endtask

  int stalls;
  int req_cycles;
  int stall_hi;
  int guard;

  initial begin
    nop();
    Clr = 1;
    cyc();
    cyc();
    Clr = 0;
    #1;
    // Reset state
    check("rst_stall",  Stall, 0);
    check("rst_req",    dm_bus.Dm_Req, 0);
    check("rst_addr",   dm_bus.Dm_Addr, 0);
    check("rst_wb_rw",  WB_RegWr, 0);
    check("rst_dout",   WB_Dout, 0);
    check("rst_memerr", MemErr, 0);

    // ALU op passes straight through in one edge
    set_op(32'h1234, 0, 5, 1, 0, 0);
    #1 check("alu_stall0", Stall, 0);
    cyc();
    check("alu_regwr",  WB_RegWr, 1);
    check("alu_rw",     WB_Rw, 5);
    check("alu_aluout", WB_ALUout, 32'h1234);
    check("alu_stall1", Stall, 0);

    // Control transfer is combinational
    nop();
    MEM_Branch = 1; MEM_Zero = 1;
    #1 check("pcsrc_bz", MEM_PCSrc, 1);
    MEM_Zero = 0;
    #1 check("pcsrc_bnz", MEM_PCSrc, 0);
    MEM_Branch = 0; MEM_Jump = 1;
    #1 check("pcsrc_j", MEM_PCSrc, 1);

    // Overflow suppresses writeback
    nop();
    set_op(32'h77, 0, 7, 1, 0, 0);
    MEM_Overflow = 1;
    cyc();
    check("ovf_regwr", WB_RegWr, 0);
    check("ovf_rw",    WB_Rw, 7);

    // Load 0x100, Ack arrives 3 cycles after Req rises
    nop();
    set_op(32'h100, 0, 3, 1, 1, 0);
    stalls = 0;
    for (int k = 0; k <= 4; k++) begin
      if (k == 4) begin
        dm_bus.Dm_Ack = 1;
        dm_bus.Dm_Rdata = 32'hDEADBEEF;
      end
      #1;
      if (Stall) stalls++;
      if (k == 1) begin
        check("ld_req",   dm_bus.Dm_Req, 1);
        check("ld_we",    dm_bus.Dm_We, 0);
        check("ld_addr",  dm_bus.Dm_Addr, 32'h100);
        check("ld_bub",   WB_RegWr, 0);
      end
      if (k == 3) check("ld_req_hold", dm_bus.Dm_Req, 1);
      if (k < 4) cyc();
    end
    cyc();
    nop();
    #1;
    check("ld_stalls", stalls, 4);
    check("ld_dout",   WB_Dout, 32'hDEADBEEF);
    check("ld_m2r",    WB_MemtoReg, 1);
    check("ld_regwr",  WB_RegWr, 1);
    check("ld_wbrw",   WB_Rw, 3);
    check("ld_reqlo",  dm_bus.Dm_Req, 0);
    check("ld_nostall", Stall, 0);

    // Misaligned store is dropped with an error pulse
    set_op(32'h103, 32'h11, 9, 1, 0, 1);
    #1 check("mis_stall", Stall, 0);
    cyc();
    check("mis_req",    dm_bus.Dm_Req, 0);
    check("mis_err",    MemErr, 1);
    check("mis_regwr",  WB_RegWr, 0);
    nop();
    cyc();
    check("mis_err_end", MemErr, 0);

    // Store 0x200 with no Ack: times out after 15 request cycles
    set_op(32'h200, 32'hCAFEF00D, 0, 0, 0, 1);
    cyc();
    check("st_we",    dm_bus.Dm_We, 1);
    check("st_wdata", dm_bus.Dm_Wdata, 32'hCAFEF00D);
    req_cycles = 0;
    stall_hi = 0;
    guard = 0;
    while (dm_bus.Dm_Req && guard < 40) begin
      req_cycles++;
      if (Stall) stall_hi++;
      if (!dm_bus.Dm_Req) break;
      cyc();
      guard++;
    end
    check("to_reqcyc", req_cycles, 15);
    check("to_stallhi", stall_hi, 14);
    check("to_err",    MemErr, 1);
    check("to_regwr",  WB_RegWr, 0);
    nop();
    #1 check("to_stall_drop", Stall, 0);
    cyc();
    check("to_err_end", MemErr, 0);

    // Zero-wait load costs a single stall cycle
    set_op(32'h40, 0, 4, 1, 1, 0);
    stalls = 0;
    #1 if (Stall) stalls++;
    cyc();
    dm_bus.Dm_Ack = 1; dm_bus.Dm_Rdata = 32'h55AA55AA;
    #1 if (Stall) stalls++;
    cyc();
    nop();
    #1;
    check("zw_stalls", stalls, 1);
    check("zw_dout",   WB_Dout, 32'h55AA55AA);

    // Ack coinciding with the last timeout cycle wins
    set_op(32'h80, 0, 6, 1, 1, 0);
    cyc();
    for (int i = 0; i < 14; i++) cyc();
    dm_bus.Dm_Ack = 1; dm_bus.Dm_Rdata = 32'h0BADF00D;
    #1 check("race_stall", Stall, 0);
    cyc();
    nop();
    #1;
    check("race_err",  MemErr, 0);
    check("race_dout", WB_Dout, 32'h0BADF00D);
    check("race_req",  dm_bus.Dm_Req, 0);

    // Ack while idle is ignored
    dm_bus.Dm_Ack = 1; dm_bus.Dm_Rdata = 32'h999;
    cyc();
    check("idle_ack_dout", WB_Dout, 32'h0BADF00D);
    check("idle_ack_req",  dm_bus.Dm_Req, 0);
    nop();

    // Clear during the second wait cycle abandons the access silently
    set_op(32'h300, 32'h12345678, 2, 1, 1, 0);
    cyc();
    cyc();
    check("clr_pre_req", dm_bus.Dm_Req, 1);
    Clr = 1;
    cyc();
    nop();
    #1;
    check("clr_req",    dm_bus.Dm_Req, 0);
    check("clr_addr",   dm_bus.Dm_Addr, 0);
    check("clr_wbrw",   WB_RegWr, 0);
    check("clr_wbrd",   WB_Rw, 0);
    check("clr_wbalu",  WB_ALUout, 0);
    check("clr_dout",   WB_Dout, 0);
    check("clr_err",    MemErr, 0);
    check("clr_stall",  Stall, 0);
    Clr = 0;
    cyc();
    check("clr_err_after", MemErr, 0);
    check("clr_req_after", dm_bus.Dm_Req, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Param TIMEOUT, default 15: max cycles waited for Dm_Ack before abort.
REQ-002 Clk  in  1  single clock; all state updates on falling edge (matches pipeline registers).
REQ-003 Clr  in  1  reset, synchronous, active-high.
REQ-004 MEM_ALUout  in  32  address for load/store, or result for ALU ops.
REQ-005 MEM_busB  in  32  store data.
REQ-006 MEM_Rw  in  5  destination register.
REQ-007 MEM_Zero / MEM_Overflow  in  1 each  ALU flags.
REQ-008 MEM_RegWr / MEM_MemtoReg / MEM_MemWr  in  1 each  controls; MemtoReg=1 marks load, MemWr=1 marks store.
REQ-009 MEM_Branch / MEM_Jump  in  1 each  control-transfer controls.
REQ-010 Dm_Rdata  in  32  memory read data, valid with Dm_Ack.
REQ-011 Dm_Ack  in  1  memory completion, one-cycle pulse.
REQ-012 MEM_PCSrc  out  1  combinational (MEM_Branch & MEM_Zero) | MEM_Jump; also flushes EX/MEM.
REQ-013 Stall  out  1  combinational; freezes IF/ID/EX/EX-MEM while high.
REQ-014 Dm_Req / Dm_We  out  1 each  registered request; We=1 store, 0 load.
REQ-015 Dm_Addr / Dm_Wdata  out  32 each  registered address/store data.
REQ-016 WB_RegWr / WB_MemtoReg  out  1 each  registered controls to WB.
REQ-017 WB_Rw  out  5; WB_ALUout / WB_Dout  out  32 each  registered WB data.
REQ-018 MemErr  out  1  registered one-cycle pulse: misaligned access or timeout.

Function
REQ-019 Mem op = MEM_MemtoReg | MEM_MemWr; aligned = MEM_ALUout[1:0]==0.
REQ-020 FSM states IDLE, WAIT; timeout counter cnt, 4 bits min, sized to hold TIMEOUT.
REQ-021 IDLE, no mem op: Stall=0; WB captures MEM_* fields each edge; WB_RegWr = MEM_RegWr & ~MEM_Overflow.
REQ-022 IDLE, aligned mem op: Stall=1; next edge Dm_Req=1, Dm_We=MEM_MemWr, Dm_Addr=MEM_ALUout, Dm_Wdata=MEM_busB, cnt=0, go WAIT; WB gets bubble (WB_RegWr=0, WB_MemtoReg=0).
REQ-023 IDLE, misaligned mem op: no request; Stall=0; MemErr pulse; WB bubble (instruction dropped).
REQ-024 WAIT: Stall=1; Dm_Req/We/Addr/Wdata held stable; cnt increments each edge; WB bubble.
REQ-025 WAIT, Dm_Ack=1: Stall=0 that cycle; next edge Dm_Req=0, go IDLE, WB_Dout=Dm_Rdata, WB_RegWr=MEM_RegWr, WB_MemtoReg=MEM_MemtoReg, WB_Rw/WB_ALUout from MEM_*.
REQ-026 WAIT, no Ack, cnt==TIMEOUT-1: Stall=0; next edge Dm_Req=0, IDLE, MemErr pulse, WB bubble.
REQ-027 Ack and timeout in same cycle: Ack wins, no MemErr.
REQ-028 Dm_Ack while IDLE ignored.
REQ-029 MEM_PCSrc independent of FSM; Branch/Jump never coincide with mem op.
REQ-030 Latency: non-mem op 1 edge to WB; load/store = 2 + ack-wait edges; zero-wait memory costs 1 stall cycle.

Reset
REQ-031 Clr high at falling edge: state IDLE, cnt=0, Dm_Req=0, Dm_We=0, Dm_Addr=0, Dm_Wdata=0, all WB_* = 0, MemErr=0; Clr mid-WAIT abandons access, no MemErr.
REQ-032 Stall=0 while in reset state with no mem op presented.

Verification
REQ-033 ALU op RegWr=1, Rw=5, ALUout=0x1234 -> next edge WB_RegWr=1, WB_Rw=5, WB_ALUout=0x1234, Stall never high.
REQ-034 Load addr 0x100, Ack 3 cycles after Req, Rdata=0xDEADBEEF -> Stall high 4 cycles, WB_Dout=0xDEADBEEF, WB_MemtoReg=1.
REQ-035 Store addr 0x103 -> no Dm_Req, MemErr one cycle, WB_RegWr=0.
REQ-036 Store addr 0x200, no Ack (TIMEOUT=15) -> Dm_Req high 15 cycles, then MemErr pulse, Stall drops.
REQ-037 Branch=1, Zero=1 -> MEM_PCSrc=1 same cycle; Overflow=1 with RegWr=1 -> WB_RegWr=0.
REQ-038 Clr asserted in WAIT cycle 2 -> next edge Dm_Req=0, IDLE, all WB_* = 0, MemErr=0.
